quadra_eval: RTL and testbench

//  Consumer side of the coefficient LUT. Accepts an input argument x and splits it into x1 (table index) and x2 (fraction).

---
 rtl/quadra_eval_if.sv | 45 ++++
 rtl/quadra_eval.sv | 140 ++++++++++++++
 tb/tb_quadra_eval.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/quadra_eval_if.sv
`default_nettype none
// ============================================================================
// Module      : quadra_eval_if
// Description : Bundles the signals between quadra_eval and its neighbours:
//               the argument handshake, the combinational coefficient LUT
//               lookup and the result handshake.
//               slave  modport : seen by quadra_eval
//               master modport : seen by the surrounding logic (source, LUT,
//                                sink)
//   in_valid/in_ready/in_x          argument handshake
//   lut_x1 -> lut_a/lut_b/lut_c     LUT index out, coefficients back
//   out_valid/out_ready/out_y/out_sat  result handshake
//   busy                            evaluator not idle
// Revision    : 1.0  initial release
// ============================================================================
interface quadra_eval_if #(
    parameter int X1_W   = 7,
    parameter int X2_W   = 17,
    parameter int COEF_W = 32,
    parameter int Y_W    = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [X1_W+X2_W-1:0]     in_x;
    logic [X1_W-1:0]          lut_x1;
    logic signed [COEF_W-1:0] lut_a;
    logic signed [COEF_W-1:0] lut_b;
    logic signed [COEF_W-1:0] lut_c;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [Y_W-1:0]    out_y;
    logic                     out_sat;
    logic                     busy;

    modport slave (
        input  in_valid, in_x, lut_a, lut_b, lut_c, out_ready,
        output in_ready, lut_x1, out_valid, out_y, out_sat, busy
    );

    modport master (
        output in_valid, in_x, lut_a, lut_b, lut_c, out_ready,
        input  in_ready, lut_x1, out_valid, out_y, out_sat, busy
    );
endinterface
`default_nettype wire

// File: rtl/quadra_eval.sv
`default_nettype none
// ============================================================================
// Module      : quadra_eval
// Description : Evaluates y = (a*x2 + b)*x2 + c by Horner's method with one
//               shared multiplier. x = {x1, x2}; x1 indexes the coefficient
//               LUT (combinational), x2 is an unsigned Q0.X2_W fraction.
//               The result is saturated to Y_W bits.
// Ports       : clk, rst (async, active high)
//               bus (quadra_eval_if.slave): argument handshake, LUT lookup,
//               result handshake, busy flag
// Revision    : 1.0  initial release
// ============================================================================
module quadra_eval #(
    parameter int X1_W   = 7,
    parameter int X2_W   = 17,
    parameter int COEF_W = 32,
    parameter int Y_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    quadra_eval_if.slave bus
);
    // Operand/intermediate widths: t1 needs one guard bit, s needs two.
    localparam int T_W  = COEF_W + 1;
    localparam int S_W  = COEF_W + 2;
    localparam int OP_W = X2_W + 1;
    localparam int P_W  = T_W + OP_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [X2_W-1:0]          r_x2;
    logic signed [COEF_W-1:0] r_a;
    logic signed [COEF_W-1:0] r_b;
    logic signed [COEF_W-1:0] r_c;
    logic signed [T_W-1:0]    r_t1;
    logic signed [Y_W-1:0]    r_y;
    logic                     r_sat;

    logic                     w_in_ready;
    logic                     w_accept;
    logic signed [T_W-1:0]    w_mul_op;
    logic signed [OP_W-1:0]   w_x2_ext;
    logic signed [P_W-1:0]    w_prod;
    logic signed [S_W-1:0]    w_prod_sh;
    logic signed [T_W-1:0]    w_t1;
    logic signed [S_W-1:0]    w_s;
    logic signed [Y_W-1:0]    w_y_sat;
    logic                     w_sat;

    // LUT index is a pure slice of the incoming argument, no register.
    assign bus.lut_x1 = bus.in_x[X1_W+X2_W-1:X2_W];
    assign bus.out_y  = r_y;
    assign bus.out_sat = r_sat;
    assign bus.in_ready = w_in_ready;

    assign w_accept = bus.in_valid && w_in_ready;

    // Shared multiplier: a in MUL1, t1 in MUL2; x2 zero-extended.
    assign w_x2_ext  = $signed({1'b0, r_x2});
    assign w_mul_op  = (r_state == MUL2) ? r_t1 : {r_a[COEF_W-1], r_a};
    assign w_prod    = P_W'(w_mul_op) * P_W'(w_x2_ext);
    // Arithmetic shift floors toward -inf; the product magnitude after the
    // shift never exceeds the operand magnitude, so S_W bits hold it.
    assign w_prod_sh = S_W'(w_prod >>> X2_W);

    assign w_t1 = w_prod_sh[T_W-1:0] + {r_b[COEF_W-1], r_b};
    assign w_s  = w_prod_sh + {{2{r_c[COEF_W-1]}}, r_c};

    // Saturate: overflow when the bits above the Y_W sign bit disagree.
    always_comb begin
        w_sat   = 1'b0;
        w_y_sat = w_s[Y_W-1:0];
        if (w_s[S_W-1:Y_W-1] != {(S_W-Y_W+1){w_s[S_W-1]}}) begin
            w_sat   = 1'b1;
            w_y_sat = w_s[S_W-1] ? {1'b1, {(Y_W-1){1'b0}}}
                                 : {1'b0, {(Y_W-1){1'b1}}};
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_in_ready    = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = MUL1;
            end
            MUL1: w_state_nxt = MUL2;
            MUL2: w_state_nxt = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                w_in_ready    = bus.out_ready;
                if (bus.out_ready) begin
                    // Back-to-back: a new argument taken in the same cycle.
                    w_state_nxt = bus.in_valid ? MUL1 : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_x2    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_t1    <= '0;
            r_y     <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_x2 <= bus.in_x[X2_W-1:0];
                r_a  <= bus.lut_a;
                r_b  <= bus.lut_b;
                r_c  <= bus.lut_c;
            end
            if (r_state == MUL1) begin
                r_t1 <= w_t1;
            end
            if (r_state == MUL2) begin
                r_y   <= w_y_sat;
                r_sat <= w_sat;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_quadra_eval.sv
`default_nettype none
// ============================================================================
// Module      : tb_quadra_eval
// Description : Self-checking bench for quadra_eval. Directed vectors from a
//               table, handshake corner cases, reset abort and a full index
//               sweep against a 64-bit reference model. Expected results go
//               into a scoreboard queue when an argument is accepted and are
//               compared when the result is transferred.
// Revision    : 1.0  initial release
// ============================================================================
module tb_quadra_eval;
    localparam int X1_W   = 7;
    localparam int X2_W   = 17;
    localparam int COEF_W = 32;
    localparam int Y_W    = 32;

    typedef struct {
        logic [23:0] x;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] y;
        logic        sat;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    bit   sweep_on;

    logic [31:0] lut_a_mem [128];
    logic [31:0] lut_b_mem [128];
    logic [31:0] lut_c_mem [128];
    logic [32:0] sb [$];
    logic [32:0] mon_exp;

    quadra_eval_if #(.X1_W(X1_W), .X2_W(X2_W), .COEF_W(COEF_W), .Y_W(Y_W)) bus ();

    quadra_eval #(.X1_W(X1_W), .X2_W(X2_W), .COEF_W(COEF_W), .Y_W(Y_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.lut_a = lut_a_mem[bus.lut_x1];
    assign bus.lut_b = lut_b_mem[bus.lut_x1];
    assign bus.lut_c = lut_c_mem[bus.lut_x1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {sat, y}.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [16:0] x2);
        longint la, lb, lc, lx, t1, s;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        lc = longint'($signed(c));
        lx = longint'({47'd0, x2});
        t1 = ((la * lx) >>> 17) + lb;
        s  = ((t1 * lx) >>> 17) + lc;
        if (s > 64'sd2147483647)       return {1'b1, 32'h7FFFFFFF};
        else if (s < -64'sd2147483648) return {1'b1, 32'h80000000};
        else                           return {1'b0, s[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one argument and wait (bounded) for it to be accepted.
    task automatic send(input logic [23:0] x, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [32:0] exp_v);
        bit done;
        done = 1'b0;
        lut_a_mem[x[23:17]] = a;
        lut_b_mem[x[23:17]] = b;
        lut_c_mem[x[23:17]] = c;
        bus.in_x     = x;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(exp_v);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: x=%h not accepted in 200 cycles", x);
        end
    endtask

    // Called right after an accept: out_valid low in MUL1/MUL2, high in OUT.
    task automatic check_latency(input string tag);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk({tag, "_latency_valid"}, 64'(bus.out_valid), 64'(k == 3));
            chk({tag, "_latency_busy"}, 64'(bus.busy), 64'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drain_left"}, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor and in_ready protocol check.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy && !bus.out_valid) begin
                checks++;
                if (bus.in_ready) begin
                    errors++;
                    $display("FAIL in_ready_in_mul: got 1 expected 0");
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got y=%h sat=%b expected no result",
                             bus.out_y, bus.out_sat);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({bus.out_sat, bus.out_y} !== mon_exp) begin
                        errors++;
                        $display("FAIL result: got y=%h sat=%b expected y=%h sat=%b",
                                 bus.out_y, bus.out_sat, mon_exp[31:0], mon_exp[32]);
                    end
                end
            end
        end
    end

    vec_t        vecs [8];
    logic [32:0] exp_a;
    logic [32:0] exp_b;
    logic [31:0] ra, rb, rc;
    logic [16:0] rx2;
    bit          seen;

    initial begin
        errors = 0;
        checks = 0;
        sweep_on = 1'b0;
        for (int i = 0; i < 128; i++) begin
            lut_a_mem[i] = 32'd0;
            lut_b_mem[i] = 32'd0;
            lut_c_mem[i] = 32'd0;
        end
        vecs[0] = '{24'h000000, 32'h12345678, 32'h9ABCDEF0, 32'h16A09E66, 32'h16A09E66, 1'b0};
        vecs[1] = '{{7'd5, 17'h10000}, 32'h0, 32'h10000000, 32'h0, 32'h08000000, 1'b0};
        vecs[2] = '{{7'd127, 17'h1FFFF}, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1};
        vecs[3] = '{{7'd64, 17'h1FFFF}, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 1'b1};
        vecs[4] = '{{7'd3, 17'h10000}, 32'h20000000, 32'h0, 32'h0, 32'h08000000, 1'b0};
        vecs[5] = '{{7'd9, 17'h00001}, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1'b0};
        vecs[6] = '{{7'd10, 17'h00001}, 32'h0, 32'h1, 32'h0, 32'h0, 1'b0};
        vecs[7] = '{{7'd11, 17'h0}, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_y", 64'(bus.out_y), 64'd0);
        chk("reset_out_sat", 64'(bus.out_sat), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table; first vector also checks latency.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].x, vecs[i].a, vecs[i].b, vecs[i].c, {vecs[i].sat, vecs[i].y});
            if (i == 0) check_latency("vec0");
        end
        drain("table");

        // Back-pressure hold, then same-cycle accept on release.
        bus.out_ready = 1'b0;
        exp_a = model(32'h01234567, 32'hFEDCBA98, 32'h0BADF00D, 17'h0ABCD);
        send({7'd20, 17'h0ABCD}, 32'h01234567, 32'hFEDCBA98, 32'h0BADF00D, exp_a);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("hold_reach_out", 64'(seen), 64'd1);
        @(posedge clk); #1;
        exp_b = model(32'hF0000000, 32'h00C0FFEE, 32'h7F000000, 17'h1F00F);
        lut_a_mem[21] = 32'hF0000000;
        lut_b_mem[21] = 32'h00C0FFEE;
        lut_c_mem[21] = 32'h7F000000;
        bus.in_x     = {7'd21, 17'h1F00F};
        bus.in_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("hold_out_y", 64'({bus.out_sat, bus.out_y}), 64'(exp_a));
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        send({7'd21, 17'h1F00F}, 32'hF0000000, 32'h00C0FFEE, 32'h7F000000, exp_b);
        check_latency("b2b");
        drain("hold");

        // Reset while in MUL2 aborts the operation.
        send({7'd30, 17'h12345}, 32'h11111111, 32'h22222222, 32'h33333333,
             model(32'h11111111, 32'h22222222, 32'h33333333, 17'h12345));
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_output", 64'(bus.out_valid), 64'd0);
            @(posedge clk); #1;
        end
        send(vecs[4].x, vecs[4].a, vecs[4].b, vecs[4].c, {vecs[4].sat, vecs[4].y});
        check_latency("after_abort");
        drain("abort");

        // Sweep every index with random coefficients and fraction.
        sweep_on = 1'b1;
        fork
            begin
                while (sweep_on) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 128; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rc  = $urandom;
            rx2 = 17'($urandom);
            if (i == 1) rx2 = 17'h1FFFF;
            if (i == 2) rx2 = 17'h0;
            send({7'(i), rx2}, ra, rb, rc, model(ra, rb, rc, rx2));
        end
        drain("sweep");
        sweep_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", 64'(bus.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
